mux8_rr_scheduler: RTL and testbench

MUX8_RR_SCHEDULER -- requirements
Module: mux8_rr_scheduler

---
 rtl/mux8_rr_scheduler.sv | 112 +++++++++++
 tb/tb_mux8_rr_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler: 8-source round-robin burst scheduler with a 1-bit data mux.
// A granted source is served for up to BURST_LEN accepted beats, then the
// arbiter idles for one bubble cycle and restarts its scan after that source.
// Optional grant-lock feature: define MUX8_SCHED_LOCK_EN to add the lock input,
// which holds the grant past the burst limit while the source keeps requesting.
module mux8_rr_scheduler #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] data_inputs,
    input  logic       out_ready,
`ifdef MUX8_SCHED_LOCK_EN
    input  logic       lock,
`endif
    output logic [2:0] select_line,
    output logic [7:0] grant,
    output logic       out_valid,
    output logic       output_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [3:0] beat_cnt;

    logic       lock_eff;
    logic       found;
    logic [2:0] pick;
    logic [2:0] idx;
    logic       xfer;
    logic       hold_cnt;
    logic       last_beat;
    logic       drop;
    logic       leave;

`ifdef MUX8_SCHED_LOCK_EN
    assign lock_eff = lock;
`else
    assign lock_eff = 1'b0;
`endif

    // Round-robin search: first requesting source at or after ptr, wrapping 7->0
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = ptr;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Burst bookkeeping; lock pins the count at 1 instead of ending the burst
    always_comb begin
        xfer      = out_valid & out_ready;
        hold_cnt  = lock_eff && (beat_cnt == 4'd1);
        last_beat = xfer && (beat_cnt == 4'd1) && !lock_eff;
        drop      = !req[select_line];
        leave     = (state == SERVE) && (last_beat || drop);
    end

    // Scheduler FSM with registered grant, select and valid outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            beat_cnt    <= '0;
            select_line <= '0;
            grant       <= '0;
            out_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state       <= SERVE;
                        select_line <= pick;
                        grant       <= 8'd1 << pick;
                        out_valid   <= 1'b1;
                        beat_cnt    <= 4'(BURST_LEN);
                    end
                end
                SERVE: begin
                    if (xfer && !hold_cnt) begin
                        beat_cnt <= beat_cnt - 4'd1;
                    end
                    if (leave) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        grant     <= '0;
                        ptr       <= select_line + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data mux is gated so the output reads 0 whenever no beat is offered
    always_comb begin
        output_data = out_valid & data_inputs[select_line];
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// tb_mux8_rr_scheduler: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a burst-level reference model.
module tb_mux8_rr_scheduler;

    localparam int unsigned BL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] data_inputs;
    logic       out_ready;
    logic       lock;
    logic [2:0] select_line;
    logic [7:0] grant;
    logic       out_valid;
    logic       output_data;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Reference model: who is being served, how many beats remain, where the next scan starts
    bit          m_busy;
    int unsigned m_sel;
    int unsigned m_left;
    int unsigned m_ptr;

    mux8_rr_scheduler #(.BURST_LEN(BL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data_inputs(data_inputs),
        .out_ready  (out_ready),
`ifdef MUX8_SCHED_LOCK_EN
        .lock       (lock),
`endif
        .select_line(select_line),
        .grant      (grant),
        .out_valid  (out_valid),
        .output_data(output_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_sel  = 0;
        m_left = 0;
        m_ptr  = 0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge
    task automatic model_update();
        bit done;
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            if (req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (req[(m_ptr + k) % 8]) begin
                        m_sel  = (m_ptr + k) % 8;
                        m_busy = 1'b1;
                        m_left = BL;
                        break;
                    end
                end
            end
        end else begin
            done = 1'b0;
            if (out_ready) begin
                if (m_left == 1 && !lock) done = 1'b1;
                else if (m_left > 1) m_left--;
            end
            if (!req[m_sel]) done = 1'b1;
            if (done) begin
                m_busy = 1'b0;
                m_ptr  = (m_sel + 1) % 8;
            end
        end
    endtask

    task automatic compare_model();
        logic exp_data;
        exp_data = m_busy ? data_inputs[m_sel] : 1'b0;
        chk("grant", grant, m_busy ? 8'(1 << m_sel) : 8'h00);
        chk("select_line", {5'b0, select_line}, 8'(m_sel));
        chk("out_valid", {7'b0, out_valid}, {7'b0, m_busy});
        chk("output_data", {7'b0, output_data}, {7'b0, exp_data});
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_model();
    endtask

    logic [7:0] seq030 [11] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                                8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01};

    initial begin
        int unsigned vcycles;
        int unsigned acc;

        rst_n       = 1'b0;
        req         = 8'h00;
        data_inputs = 8'hFF;
        out_ready   = 1'b0;
        lock        = 1'b0;
        model_reset();
        @(negedge clk);
        compare_model();
        chk("reset_grant", grant, 8'h00);
        chk("reset_valid", {7'b0, out_valid}, 8'h00);
        chk("reset_data", {7'b0, output_data}, 8'h00);
        step();
        step();
        rst_n = 1'b1;

        // Two requesters alternate with a bubble between bursts
        req       = 8'h81;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            chk("r030_grant", grant, seq030[i]);
        end

        // Drop request to end the burst; scan resumes at source 1
        req = 8'h00;
        step();
        step();

        // Throttled consumer: grant held until the fourth accepted beat
        req = 8'h04;
        step();
        vcycles = 0;
        acc     = 0;
        for (int j = 0; j < 7; j++) begin
            out_ready = (j % 2 == 0);
            chk("r031_hold", grant, 8'h04);
            if (out_valid) vcycles++;
            if (out_valid && out_ready) acc++;
            step();
        end
        chk("r031_valid_after", {7'b0, out_valid}, 8'h00);
        chk("r031_vcycles", 8'(vcycles), 8'd7);
        chk("r031_beats", 8'(acc), 8'd4);
        req       = 8'h00;
        out_ready = 1'b1;
        step();

        // Wrap-around: after serving source 6 the scan starts at 7 and wraps to 0
        req = 8'h40;
        step();
        chk("r032_src6", grant, 8'h40);
        req = 8'h00;
        step();
        req = 8'h01;
        step();
        chk("r032_sel", {5'b0, select_line}, 8'h00);
        chk("r032_grant", grant, 8'h01);
        req = 8'h00;
        step();

        // Request drops together with the second accepted beat
        req = 8'h08;
        step();
        chk("r033_grant", grant, 8'h08);
        acc = 0;
        if (out_valid && out_ready) acc++;
        step();
        req = 8'h00;
        if (out_valid && out_ready) acc++;
        step();
        chk("r033_beats", 8'(acc), 8'd2);
        chk("r033_exit", {7'b0, out_valid}, 8'h00);
        req = 8'hFF;
        step();
        chk("r033_next_ptr", grant, 8'h10);

        // Reset pulse in the middle of a source-5 burst
        req = 8'h00;
        step();
        req = 8'h20;
        step();
        chk("r034_src5", grant, 8'h20);
        step();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("r034_grant_rst", grant, 8'h00);
        chk("r034_valid_rst", {7'b0, out_valid}, 8'h00);
        chk("r034_data_rst", {7'b0, output_data}, 8'h00);
        step();
        rst_n = 1'b1;
        req   = 8'hFF;
        step();
        chk("r034_restart", grant, 8'h01);

`ifdef MUX8_SCHED_LOCK_EN
        // Lock holds the grant past the burst limit until released
        req = 8'h00;
        step();
        step();
        req       = 8'h02;
        lock      = 1'b1;
        out_ready = 1'b1;
        step();
        acc = 0;
        for (int j = 0; j < 10; j++) begin
            if (out_valid && out_ready && grant == 8'h02) acc++;
            step();
        end
        chk("r035_beats", 8'(acc), 8'd10);
        chk("r035_still", grant, 8'h02);
        lock = 1'b0;
        step();
        chk("r035_exit", {7'b0, out_valid}, 8'h00);
        req = 8'h00;
        step();
`endif

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom & $urandom);
            data_inputs = 8'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
`ifdef MUX8_SCHED_LOCK_EN
            lock = ($urandom_range(0, 2) == 0);
`endif
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_model();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
